brief_desc_collector: RTL

- Receiving end of the BRIEF descriptor output stream (flag, coordinates, descriptor, depth, score, start/end).
- Stores each frame's descriptors in a ping-pong dual-port SRAM: bank A is written with the current frame while bank B holds the previous frame for readout.
- Serves the previous frame to the downstream matcher over a valid/ready stream.
- Sits between the BRIEF stage and the frame-to-frame matcher in the VO pipeline.

---
 rtl/brief_pkg.sv | 44 ++++
 rtl/brief_desc_reader.sv | 118 +++++++++++
 rtl/brief_desc_collector.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/brief_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brief_pkg
// Description : Shared types and defaults for the BRIEF descriptor collector.
//               Holds the SRAM record layout, default sizing and the state
//               encodings of the write and read state machines.
// Revision    : 1.0 - initial release
// ============================================================================
package brief_pkg;

    // Default sizing: up to 100 descriptors per frame, 8-bit SRAM address
    // (bank bit + 7-bit index).
    localparam int MAX_KP_DEF = 100;
    localparam int AW_DEF     = 8;

    // Record counts travel on 8-bit buses (o_prev_count is 8 bits wide).
    localparam int CNT_W      = 8;

    // SRAM record, MSB to LSB: {descriptor, x, y, depth, score}.
    typedef struct packed {
        logic [255:0] desc;
        logic [9:0]   x;
        logic [9:0]   y;
        logic [15:0]  depth;
        logic [7:0]   score;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_COLLECT = 2'd1,
        W_SKIP    = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_HOLD  = 2'd3
    } rstate_t;

endpackage : brief_pkg
`default_nettype wire

// File: rtl/brief_desc_reader.sv
`default_nettype none
// ============================================================================
// Module      : brief_desc_reader
// Description : Read side of the descriptor collector. Streams the previous
//               frame out of the ping-pong SRAM over a valid/ready interface,
//               one record per ISSUE/WAIT/HOLD sequence.
// Ports       : clk, rst_n      - clock, async active-low reset
//               rd_req          - start a readout of the previous frame
//               rd_ready        - consumer ready
//               wbank           - bank currently owned by the writer
//               prev_count      - number of records in the previous frame
//               sram_qb         - SRAM port-B data (1-cycle latency)
//               sram_ab         - SRAM port-B address
//               rd_idle         - read FSM is idle
//               rd_valid/last   - output record valid / final record
//               rd_done         - one-cycle pulse when readout completes
//               rd_rec          - output record
// Revision    : 1.0 - initial release
// ============================================================================
module brief_desc_reader
    import brief_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic             rd_ready,
    input  logic             wbank,
    input  logic [CNT_W-1:0] prev_count,
    input  logic [REC_W-1:0] sram_qb,
    output logic [AW-1:0]    sram_ab,
    output logic             rd_idle,
    output logic             rd_valid,
    output logic             rd_last,
    output logic             rd_done,
    output rec_t             rd_rec
);

    rstate_t          state;
    rstate_t          state_nxt;
    logic             rbank;
    logic [CNT_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_cnt;   // count latched at readout start

    logic             start_rd;
    logic             empty_req;
    logic             capture;
    logic             handshake;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  if (rd_req && (prev_count != '0)) state_nxt = R_ISSUE;
            R_ISSUE: state_nxt = R_WAIT;
            R_WAIT:  state_nxt = R_HOLD;
            R_HOLD:  if (rd_ready) state_nxt = rd_last ? R_IDLE : R_ISSUE;
            default: state_nxt = R_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        sram_ab   = {rbank, rd_idx[AW-2:0]};
        rd_idle   = (state == R_IDLE);
        start_rd  = rd_idle && rd_req && (prev_count != '0);
        empty_req = rd_idle && rd_req && (prev_count == '0);
        capture   = (state == R_WAIT);
        handshake = (state == R_HOLD) && rd_ready;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank    <= 1'b0;
            rd_idx   <= '0;
            rd_cnt   <= '0;
            rd_rec   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            rd_done <= empty_req || (handshake && rd_last);

            if (start_rd) begin
                // The previous frame lives in the bank the writer is not using.
                rbank  <= ~wbank;
                rd_idx <= '0;
                rd_cnt <= prev_count;
            end else if (handshake && !rd_last) begin
                rd_idx <= rd_idx + CNT_W'(1);
            end

            if (capture) begin
                rd_rec   <= rec_t'(sram_qb);
                rd_valid <= 1'b1;
                rd_last  <= (rd_idx == rd_cnt - CNT_W'(1));
            end else if (handshake) begin
                rd_valid <= 1'b0;
                if (rd_last) begin
                    rd_last <= 1'b0;
                end
            end
        end
    end

endmodule : brief_desc_reader
`default_nettype wire

// File: rtl/brief_desc_collector.sv
`default_nettype none
// ============================================================================
// Module      : brief_desc_collector
// Description : Collects BRIEF descriptors per frame into a ping-pong SRAM
//               (one bank written, the other holding the previous frame) and
//               serves the previous frame to the matcher.
// Ports       : i_clk, i_rst_n          - clock, async active-low reset
//               i_start/i_end/i_flag    - frame framing and descriptor valid
//               i_coor_x/y, i_descriptor, i_depth, i_score - descriptor data
//               i_rd_req, i_rd_ready    - readout request / consumer ready
//               o_rd_*                  - output record stream
//               o_prev_count            - records in the previous frame
//               o_frame_ready, o_overflow, o_drop - frame status
//               o_sram_*, i_sram_QB     - dual-port SRAM interface
// Revision    : 1.0 - initial release
// ============================================================================
module brief_desc_collector
    import brief_pkg::*;
#(
    parameter int MAX_KP = MAX_KP_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_end,
    input  logic             i_flag,
    input  logic [9:0]       i_coor_x,
    input  logic [9:0]       i_coor_y,
    input  logic [255:0]     i_descriptor,
    input  logic [15:0]      i_depth,
    input  logic [7:0]       i_score,
    input  logic             i_rd_req,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [9:0]       o_rd_x,
    output logic [9:0]       o_rd_y,
    output logic [255:0]     o_rd_desc,
    output logic [15:0]      o_rd_depth,
    output logic [7:0]       o_rd_score,
    output logic             o_rd_last,
    output logic             o_rd_done,
    output logic [7:0]       o_prev_count,
    output logic             o_frame_ready,
    output logic             o_overflow,
    output logic             o_drop,
    output logic             o_sram_WENA,
    output logic [AW-1:0]    o_sram_AA,
    output logic [REC_W-1:0] o_sram_DA,
    output logic [AW-1:0]    o_sram_AB,
    input  logic [REC_W-1:0] i_sram_QB
);

    wstate_t          wstate;
    wstate_t          wstate_nxt;
    logic             wbank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] prev_count;
    logic             sram_wena;
    logic [AW-1:0]    sram_aa;
    rec_t             sram_da;
    logic             frame_ready;
    logic             overflow;
    logic             drop;

    rec_t             rec_in;
    rec_t             rd_rec;
    logic             rd_idle;

    logic             accept;
    logic             ovf_hit;
    logic             close;
    logic             open;
    logic             conflict;

    assign rec_in = {i_descriptor, i_coor_x, i_coor_y, i_depth, i_score};

    // A new frame would write into ~rbank's complement, i.e. the bank being
    // read. A readout being accepted this very cycle counts as active too,
    // so a frame opening alongside the request is also discarded.
    assign conflict = !rd_idle || (i_rd_req && (prev_count != '0));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    // Next-state logic; an i_end/i_start pair closes and reopens in one step
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE, W_COLLECT, W_SKIP: begin
                if (open) begin
                    wstate_nxt = conflict ? W_SKIP : W_COLLECT;
                end else if (i_end && (wstate != W_IDLE)) begin
                    wstate_nxt = W_IDLE;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        accept  = 1'b0;
        ovf_hit = 1'b0;
        close   = 1'b0;
        if (wstate == W_COLLECT) begin
            if (i_flag) begin
                if (wr_cnt < CNT_W'(MAX_KP)) begin
                    accept = 1'b1;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
            close = i_end;
        end
        open = i_start && ((wstate == W_IDLE) || (i_end && (wstate != W_IDLE)));
    end

    // Bank, count, status and SRAM write registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbank       <= 1'b0;
            wr_cnt      <= '0;
            prev_count  <= '0;
            sram_wena   <= 1'b1;
            sram_aa     <= '0;
            sram_da     <= '0;
            frame_ready <= 1'b0;
            overflow    <= 1'b0;
            drop        <= 1'b0;
        end else begin
            sram_wena   <= ~accept;
            frame_ready <= close;
            drop        <= open && conflict;

            // Address uses the pre-toggle bank so a flag arriving with i_end
            // still lands in the closing frame.
            if (accept) begin
                sram_aa <= {wbank, wr_cnt[AW-2:0]};
                sram_da <= rec_in;
            end

            if (open) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end

            if (close) begin
                prev_count <= wr_cnt + CNT_W'(accept);
                wbank      <= ~wbank;
            end

            if (open) begin
                overflow <= 1'b0;
            end else if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

    brief_desc_reader #(
        .AW (AW)
    ) u_reader (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .rd_req     (i_rd_req),
        .rd_ready   (i_rd_ready),
        .wbank      (wbank),
        .prev_count (prev_count),
        .sram_qb    (i_sram_QB),
        .sram_ab    (o_sram_AB),
        .rd_idle    (rd_idle),
        .rd_valid   (o_rd_valid),
        .rd_last    (o_rd_last),
        .rd_done    (o_rd_done),
        .rd_rec     (rd_rec)
    );

    assign o_rd_x        = rd_rec.x;
    assign o_rd_y        = rd_rec.y;
    assign o_rd_desc     = rd_rec.desc;
    assign o_rd_depth    = rd_rec.depth;
    assign o_rd_score    = rd_rec.score;
    assign o_prev_count  = prev_count;
    assign o_frame_ready = frame_ready;
    assign o_overflow    = overflow;
    assign o_drop        = drop;
    assign o_sram_WENA   = sram_wena;
    assign o_sram_AA     = sram_aa;
    assign o_sram_DA     = sram_da;

endmodule : brief_desc_collector
`default_nettype wire
